// File: rtl/matrix_op_pkg.sv
// Shared constants, reader FSM states and the element record carried through
// the output FIFO of matrix_stream_reader.
package matrix_op_pkg;

  localparam int META_ROWS_MSB = 31;
  localparam int META_ROWS_LSB = 24;
  localparam int META_COLS_MSB = 23;
  localparam int META_COLS_LSB = 16;

  localparam int MAX_MATRICES  = 8;
  localparam int SEL_W         = $clog2(MAX_MATRICES);
  localparam int META_OFFSET   = 0;
  localparam int DATA_OFFSET   = 1;

  typedef enum logic [2:0] {
    IDLE, CHECK_SEL, READ_META, WAIT_META, LOAD_META, STREAM, FINISH
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        last;
  } elem_t;

  function automatic logic [15:0] elem_count(input logic [7:0] r, input logic [7:0] c);
    return 16'(r) * 16'(c);
  endfunction

endpackage

// File: rtl/matrix_stream_reader_if.sv
// Element stream towards the compute datapath: valid/ready with row/col tags.
interface matrix_stream_if;
  logic [31:0] out_data;
  logic [7:0]  out_row;
  logic [7:0]  out_col;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, out_row, out_col, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_row, out_col, out_last, out_valid, output out_ready);
endinterface

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO of element records; head is shown combinationally.
module stream_fifo2
  import matrix_op_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  elem_t      din,
  output elem_t      dout,
  output logic [1:0] count
);
  elem_t      r_mem [2];
  logic       r_wp, r_rp;
  logic [1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(push) - 2'(pop);
    end
  end

  assign dout  = r_mem[r_rp];
  assign count = r_cnt;
endmodule

// File: rtl/matrix_stream_reader.sv
// Validates a matrix selection, reads its metadata word from BRAM and streams
// rows*cols elements row-major through a 2-entry FIFO at one element per cycle.
module matrix_stream_reader
  import matrix_op_pkg::*;
#(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SEL_W-1:0]        sel_id,
  input  logic [MAX_MATRICES-1:0] valid_mask,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  input  logic [31:0]             bram_data,
  matrix_stream_if.master         o_stream,
  output logic [7:0]              rows,
  output logic [7:0]              cols,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);
  state_t                  r_state, w_next;
  logic [SEL_W-1:0]        r_sel;
  logic [MAX_MATRICES-1:0] r_mask;
  logic [7:0]              r_rows, r_cols, r_row, r_col, r_tag_row, r_tag_col;
  logic [15:0]             r_n, r_k;
  logic                    r_inflight, r_tag_last, r_busy, r_err;

  logic [ADDR_WIDTH-1:0]   w_base;
  logic [7:0]              w_meta_rows, w_meta_cols;
  logic [15:0]             w_meta_n;
  logic                    w_meta_bad, w_pop, w_issue;
  logic [1:0]              w_cnt;
  logic [2:0]              w_credit;
  elem_t                   w_push_elem, w_head;

  assign w_base      = ADDR_WIDTH'(32'(r_sel) * BLOCK_SIZE);
  assign w_meta_rows = bram_data[META_ROWS_MSB:META_ROWS_LSB];
  assign w_meta_cols = bram_data[META_COLS_MSB:META_COLS_LSB];
  assign w_meta_n    = elem_count(w_meta_rows, w_meta_cols);
  assign w_meta_bad  = (w_meta_rows == 8'd0) || (w_meta_cols == 8'd0) ||
                       (w_meta_n > 16'(BLOCK_SIZE - 1));

  // The pop in the same cycle frees a slot, so a read may be issued against it;
  // this keeps one element per cycle with only two FIFO entries.
  assign w_pop    = o_stream.out_valid && o_stream.out_ready;
  assign w_credit = 3'(w_cnt) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue  = (r_state == STREAM) && (r_k < r_n) && (w_credit < 3'd2);

  assign w_push_elem = '{data: bram_data, row: r_tag_row, col: r_tag_col, last: r_tag_last};

  stream_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight),
    .pop   (w_pop),
    .din   (w_push_elem),
    .dout  (w_head),
    .count (w_cnt)
  );

  assign o_stream.out_data  = w_head.data;
  assign o_stream.out_row   = w_head.row;
  assign o_stream.out_col   = w_head.col;
  assign o_stream.out_last  = w_head.last;
  assign o_stream.out_valid = (w_cnt != 2'd0);

  // Address is held at base through WAIT_META so bram_data stays on the metadata word.
  always_comb begin
    bram_addr = '0;
    case (r_state)
      READ_META, WAIT_META, LOAD_META: bram_addr = w_base + ADDR_WIDTH'(META_OFFSET);
      STREAM:  bram_addr = w_base + ADDR_WIDTH'(DATA_OFFSET) + ADDR_WIDTH'(r_k);
      default: bram_addr = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (start) w_next = CHECK_SEL;
      CHECK_SEL: w_next = r_mask[r_sel] ? READ_META : FINISH;
      READ_META: w_next = WAIT_META;
      WAIT_META: w_next = LOAD_META;
      LOAD_META: w_next = w_meta_bad ? FINISH : STREAM;
      STREAM:    if (w_pop && o_stream.out_last) w_next = FINISH;
      FINISH:    w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_mask     <= '0;
      r_rows     <= '0;
      r_cols     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_inflight <= 1'b0;
      r_tag_row  <= '0;
      r_tag_col  <= '0;
      r_tag_last <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_row  <= r_row;
        r_tag_col  <= r_col;
        r_tag_last <= (r_k == r_n - 16'd1);
        r_k        <= r_k + 16'd1;
        if (r_col == r_cols - 8'd1) begin
          r_col <= '0;
          r_row <= r_row + 8'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
      end
      case (r_state)
        IDLE: if (start) begin
          r_sel  <= sel_id;
          r_mask <= valid_mask;
          r_busy <= 1'b1;
          r_err  <= 1'b0;
        end
        CHECK_SEL: if (!r_mask[r_sel]) r_err <= 1'b1;
        LOAD_META: begin
          r_rows <= w_meta_rows;
          r_cols <= w_meta_cols;
          r_n    <= w_meta_n;
          r_k    <= '0;
          r_row  <= '0;
          r_col  <= '0;
          if (w_meta_bad) r_err <= 1'b1;
        end
        default: ;
      endcase
      if (w_next == FINISH) r_busy <= 1'b0;
    end
  end

  assign rows  = r_rows;
  assign cols  = r_cols;
  assign busy  = r_busy;
  assign done  = (r_state == FINISH);
  assign error = done && r_err;
endmodule

// File: tb/tb_matrix_stream_reader.sv
// Self-checking bench: BRAM model, element-queue reference model and a
// per-cycle compare process on the output stream.
module tb_matrix_stream_reader;
  localparam int BLK = 1152;
  localparam int AW  = 14;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  r;
    logic [7:0]  c;
    logic        l;
  } ex_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    sel_id = '0;
  logic [7:0]    valid_mask = '0;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_data;
  logic [7:0]    rows, cols;
  logic          busy, done, error;

  matrix_stream_if sif ();

  matrix_stream_reader #(.BLOCK_SIZE(BLK), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel_id(sel_id), .valid_mask(valid_mask),
    .bram_addr(bram_addr), .bram_data(bram_data), .o_stream(sif),
    .rows(rows), .cols(cols), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  always @(posedge clk) bram_data <= mem[bram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_chk = 0, n_fail = 0;
  int  n_done = 0, n_err = 0, addr_nz = 0;
  int  first_cyc = 0, last_cyc = 0, cs = 0;
  int  m_rows = 0, m_cols = 0;
  int  rdy_mode = 0, stall = 0;
  ex_t exp_q[$];
  ex_t acc_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall > 0) begin
        sif.out_ready = 1'b0;
        stall--;
      end else if (rdy_mode == 0) sif.out_ready = 1'b1;
      else sif.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Compare process: every accepted element against the model queue, plus hold-stability.
  initial begin
    logic        pv, pr;
    logic [48:0] pbits;
    ex_t         e;
    pv = 1'b0; pr = 1'b0; pbits = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 1'b0;
      else begin
        if (bram_addr != '0) addr_nz++;
        if (pv && !pr) begin
          chk("hold_valid", 64'(sif.out_valid), 64'd1);
          chk("hold_data", {sif.out_data, sif.out_row, sif.out_col, sif.out_last}, pbits);
        end
        if (sif.out_valid) chk("busy_in_stream", 64'(busy), 64'd1);
        if (sif.out_valid && sif.out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_xfer: got %0h expected none", sif.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("xfer", {sif.out_data, sif.out_row, sif.out_col, sif.out_last}, {e.d, e.r, e.c, e.l});
          end
          if (acc_q.size() == 0) first_cyc = cyc;
          last_cyc = cyc;
          e.d = sif.out_data; e.r = sif.out_row; e.c = sif.out_col; e.l = sif.out_last;
          acc_q.push_back(e);
        end
        if (done) n_done++;
        if (error) begin
          n_err++;
          chk("error_with_done", 64'(done), 64'd1);
        end
        pv = sif.out_valid; pr = sif.out_ready;
        pbits = {sif.out_data, sif.out_row, sif.out_col, sif.out_last};
      end
    end
  end

  task automatic set_meta(input int id, input int r, input int c);
    mem[id*BLK] = {8'(r), 8'(c), 16'h0000};
  endtask

  task automatic expect_run(input int id, input logic [7:0] mask, output bit rej, output int n);
    logic [31:0] meta;
    int r, c;
    meta = mem[id*BLK];
    r = int'(meta[31:24]);
    c = int'(meta[23:16]);
    n = r * c;
    rej = !mask[id] || r == 0 || c == 0 || n > BLK - 1;
    if (mask[id]) begin m_rows = r; m_cols = c; end
    if (rej) n = 0;
    else for (int k = 0; k < n; k++) begin
      ex_t e;
      e.d = mem[id*BLK + 1 + k];
      e.r = 8'(k / c);
      e.c = 8'(k % c);
      e.l = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int id, input logic [7:0] mask);
    acc_q.delete();
    addr_nz = 0;
    @(posedge clk); #1;
    start = 1'b1; sel_id = 3'(id); valid_mask = mask; cs = cyc;
    @(posedge clk); #1;
    start = 1'b0; sel_id = 3'($urandom); valid_mask = 8'($urandom);
  endtask

  // mode: 0 plain, 1 re-pulse start mid-stream, 2 five-cycle ready stall mid-stream
  task automatic run(input int id, input logic [7:0] mask, input int mode, output int rel);
    bit rej, got, poked;
    int n, nd0, ne0, dcyc;
    nd0 = n_done; ne0 = n_err;
    got = 0; poked = 0; dcyc = 0;
    expect_run(id, mask, rej, n);
    pulse_start(id, mask);
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (done) begin got = 1; dcyc = cyc; end
      else if (mode != 0 && !poked && acc_q.size() >= 2) begin
        poked = 1;
        if (mode == 2) stall = 5;
        else begin
          @(posedge clk); #1; start = 1'b1; sel_id = 3'd5; valid_mask = 8'h00;
          @(posedge clk); #1; start = 1'b0;
        end
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    rel = dcyc - cs;
    chk("done_count", 64'(n_done - nd0), 64'd1);
    chk("error_flag", 64'(n_err - ne0), 64'(rej));
    chk("xfer_count", 64'(acc_q.size()), 64'(n));
    chk("model_drained", 64'(exp_q.size()), 64'd0);
    chk("rows", 64'(rows), 64'(m_rows));
    chk("cols", 64'(cols), 64'(m_cols));
    if (!rej) begin
      chk("done_after_last", 64'(dcyc - last_cyc), 64'd1);
      chk("last_is_last_elem", 64'(acc_q[acc_q.size()-1].l), 64'd1);
      if (rdy_mode == 0 && mode != 2) begin
        chk("first_latency", 64'(first_cyc - cs), 64'd7);
        chk("throughput", 64'(last_cyc - first_cyc), 64'(n - 1));
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_ctl", {bram_addr, rows, cols, busy, done, error}, 64'd0);
    chk("rst_out", {sif.out_data, sif.out_row, sif.out_col, sif.out_last, sif.out_valid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_rows = 0; m_cols = 0;
  endtask

  initial begin
    int  rel, nd0, r, c, id;
    bit  got, rej;
    int  n;
    logic [7:0] mask;

    for (int i = 0; i < 16384; i++) mem[i] = '0;
    set_meta(3, 2, 3);
    for (int k = 0; k < 6; k++) mem[3*BLK + 1 + k] = 32'(k + 1);
    set_meta(2, 3, 3);
    for (int k = 0; k < 9; k++) mem[2*BLK + 1 + k] = 32'(10 + k);
    set_meta(1, 1, 1);
    mem[1*BLK + 1] = 32'h0000_00AA;
    set_meta(0, 0, 0);

    do_reset();

    // 2x3 matrix, ready high
    rdy_mode = 0;
    run(3, 8'h08, 0, rel);
    chk("t1_done_cycle", 64'(rel), 64'd13);
    for (int k = 0; k < 6; k++) begin
      chk("t1_data", 64'(acc_q[k].d), 64'(k + 1));
      chk("t1_last", 64'(acc_q[k].l), 64'(k == 5));
    end
    chk("t1_rc_last", {acc_q[5].r, acc_q[5].c}, 64'h0102);
    chk("t1_rows_cols", {rows, cols}, 64'h0203);

    // rejected selection: no BRAM access
    run(5, 8'h08, 0, rel);
    chk("t2_done_cycle", 64'(rel), 64'd2);
    chk("t2_no_addr", 64'(addr_nz), 64'd0);

    // zero-size metadata
    run(0, 8'h01, 0, rel);
    chk("t3_done_cycle", 64'(rel), 64'd5);
    chk("t3_rows_cols", {rows, cols}, 64'h0000);

    // 3x3 with random ready and a forced 5-cycle stall
    rdy_mode = 1;
    run(2, 8'h04, 2, rel);
    chk("t4_last_data", 64'(acc_q[8].d), 64'd18);
    rdy_mode = 0;

    // reset after 4 of 9 transfers, then 1x1 on ID 1
    expect_run(2, 8'h04, rej, n);
    pulse_start(2, 8'h04);
    nd0 = n_done;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (acc_q.size() >= 4) got = 1;
    end
    chk("t5_reached4", 64'(got), 64'd1);
    do_reset();
    chk("t5_xfers_before_rst", 64'(acc_q.size()), 64'd4);
    chk("t5_no_done", 64'(n_done), 64'(nd0));
    run(1, 8'h02, 0, rel);
    chk("t5_data", {acc_q[0].d, acc_q[0].l}, {32'h0000_00AA, 1'b1});
    chk("t5_done_cycle", 64'(rel), 64'd8);

    // start pulsed mid-stream must be ignored
    run(3, 8'h08, 1, rel);
    chk("t6_done_cycle", 64'(rel), 64'd13);

    // size boundary: 36x32 = 1152 rejected (rows/cols still latched), 46x25 = 1150 accepted
    set_meta(4, 36, 32);
    run(4, 8'h10, 0, rel);
    chk("big_rows_cols", {rows, cols}, 64'h2420);
    set_meta(6, 46, 25);
    for (int k = 0; k < 1150; k++) mem[6*BLK + 1 + k] = $urandom;
    run(6, 8'h40, 0, rel);
    chk("max_done_cycle", 64'(rel), 64'd1157);

    // randomized runs
    for (int t = 0; t < 10; t++) begin
      id = $urandom_range(0, 7);
      r  = $urandom_range(0, 5);
      c  = $urandom_range(1, 5);
      set_meta(id, r, c);
      for (int k = 0; k < r * c; k++) mem[id*BLK + 1 + k] = $urandom;
      mask = 8'($urandom);
      if ($urandom_range(0, 3) != 0) mask[id] = 1'b1;
      rdy_mode = $urandom_range(0, 1);
      run(id, mask, 0, rel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
